// File: rtl/alu_rotate_sequencer.sv
// -----------------------------------------------------------------------------
// alu_rotate_sequencer
//   Multi-cycle shift/rotate unit for the 8-bit ALU. A request (operand, op,
//   amount) is captured on start while not busy. The unit then applies one
//   1-bit rotate/shift step per clock and publishes the registered result,
//   carry and zero flag together with a one-cycle done pulse.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request; sampled only when busy==0
//   op         in   2      00 ROR, 01 ROL, 10 SHR, 11 SHL (zero fill)
//   operand    in   WIDTH  value to shift; sampled with start
//   amount     in   CNT_W  number of 1-bit steps; sampled with start
//   busy       out  1      high while in SHIFT
//   done       out  1      one-cycle pulse; result/flags valid
//   result     out  WIDTH  shifted value; held until next completion
//   carry_out  out  1      last bit shifted out (0 if amount==0)
//   zero_flag  out  1      result == 0
// -----------------------------------------------------------------------------
module alu_rotate_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_ROL = 2'b01,
    OP_SHR = 2'b10,
    OP_SHL = 2'b11
  } op_e;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] work_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             zero_flag_q;
  logic             busy_q;
  logic             done_q;

  // Single 1-bit step of the working value, plus the bit that falls out.
  logic [WIDTH-1:0] work_d;
  logic             shout_d;

  always_comb begin
    work_d  = work_q;
    shout_d = 1'b0;
    unique case (op_q)
      OP_ROR: begin
        work_d  = {work_q[0], work_q[WIDTH-1:1]};
        shout_d = work_q[0];
      end
      OP_ROL: begin
        work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        shout_d = work_q[WIDTH-1];
      end
      OP_SHR: begin
        work_d  = {1'b0, work_q[WIDTH-1:1]};
        shout_d = work_q[0];
      end
      OP_SHL: begin
        work_d  = {work_q[WIDTH-2:0], 1'b0};
        shout_d = work_q[WIDTH-1];
      end
      default: begin
        work_d  = work_q;
        shout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ROR;
      work_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          // DONE behaves like IDLE for acceptance, so a held start chains
          // the next request without an idle cycle.
          done_q <= 1'b0;
          if (start) begin
            work_q  <= operand;
            cnt_q   <= amount;
            op_q    <= op_e'(op);
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            work_q  <= work_d;
            cnt_q   <= cnt_q - 1'b1;
            carry_q <= shout_d;
          end else begin
            result_q    <= work_q;
            carry_out_q <= carry_q;
            zero_flag_q <= (work_q == '0);
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero_flag = zero_flag_q;

endmodule

// File: tb/tb_alu_rotate_sequencer.sv
module tb_alu_rotate_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] operand;
  logic [2:0] amount;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       zero_flag;

  int n_cmp = 0;
  int n_err = 0;

  alu_rotate_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand   (operand),
    .amount    (amount),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form reference: rotate/shift by n positions at once.
  task automatic ref_calc(input logic [1:0] o, input logic [7:0] x, input logic [2:0] a,
                          output logic [7:0] r, output logic c);
    int v;
    int n;
    v = int'(x);
    n = int'(a);
    case (o)
      2'd0: begin r = 8'(((v >> n) | (v << (8 - n))) & 255); c = (n == 0) ? 1'b0 : 1'((v >> (n - 1)) & 1); end
      2'd1: begin r = 8'(((v << n) | (v >> (8 - n))) & 255); c = (n == 0) ? 1'b0 : 1'((v >> (8 - n)) & 1); end
      2'd2: begin r = 8'(v >> n);                            c = (n == 0) ? 1'b0 : 1'((v >> (n - 1)) & 1); end
      default: begin r = 8'((v << n) & 255);                 c = (n == 0) ? 1'b0 : 1'((v >> (8 - n)) & 1); end
    endcase
  endtask

  // Issue one request from an idle unit (called on a negedge) and check it.
  // When pulse_mid is set, start is re-pulsed with garbage during SHIFT.
  task automatic do_op(input logic [1:0] o, input logic [7:0] x, input logic [2:0] a,
                       input bit pulse_mid);
    logic [7:0] er;
    logic       ec;
    int         k;
    int         busy_cnt;
    ref_calc(o, x, a, er, ec);
    op = o; operand = x; amount = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); operand = 8'($urandom); amount = 3'($urandom);
    k = 1;
    busy_cnt = 0;
    while (k < 20 && done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      k++;
      if (pulse_mid && k == 2) start = 1'b1;
      if (pulse_mid && k == 3) start = 1'b0;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", k, int'(a) + 2);
    chk("busy_cycles", busy_cnt, int'(a) + 1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(er));
    chk("carry", 32'(carry_out), 32'(ec));
    chk("zero", 32'(zero_flag), 32'(er == 8'd0));
    $display("op=%0d operand=%02h amount=%0d -> result=%02h carry=%0b zero=%0b latency=%0d",
             o, x, a, result, carry_out, zero_flag, k);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("result_held", 32'(result), 32'(er));
  endtask

  initial begin
    logic [7:0] er1, er2;
    logic       ec1, ec2;
    int         k;
    int         seen;

    rst_n = 1'b0; start = 1'b0; op = 2'd0; operand = 8'd0; amount = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(2'd0, 8'hCA, 3'd1, 1'b0);
    do_op(2'd0, 8'h0F, 3'd4, 1'b0);
    do_op(2'd1, 8'h81, 3'd1, 1'b0);
    do_op(2'd2, 8'h01, 3'd1, 1'b0);
    do_op(2'd3, 8'hFF, 3'd7, 1'b0);
    do_op(2'd0, 8'h0F, 3'd4, 1'b1);
    do_op(2'd1, 8'h5A, 3'd0, 1'b0);

    // Back-to-back: start held through DONE, second request chained.
    ref_calc(2'd1, 8'h81, 3'd2, er1, ec1);
    ref_calc(2'd2, 8'hF0, 3'd3, er2, ec2);
    op = 2'd1; operand = 8'h81; amount = 3'd2; start = 1'b1;
    k = 0;
    while (k < 20 && done !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat1", k, 4);
    chk("b2b_res1", 32'(result), 32'(er1));
    chk("b2b_carry1", 32'(carry_out), 32'(ec1));
    op = 2'd2; operand = 8'hF0; amount = 3'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    k = 1;
    while (k < 20 && done !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_lat2", k, 5);
    chk("b2b_res2", 32'(result), 32'(er2));
    chk("b2b_carry2", 32'(carry_out), 32'(ec2));
    $display("back-to-back: first=%02h second=%02h", er1, result);
    @(negedge clk);

    // Random requests against the reference model
    for (int i = 0; i < 30; i++) begin
      do_op(2'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)) && 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      do_op(2'($urandom), 8'($urandom), 3'($urandom_range(2, 7)), 1'b1);
    end

    // Leave a nonzero result, then reset mid-SHIFT.
    do_op(2'd0, 8'h5A, 3'd0, 1'b0);
    op = 2'd0; operand = 8'hCA; amount = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", 32'(result), 32'd0);
    chk("async_rst_carry", 32'(carry_out), 32'd0);
    chk("async_rst_zero", 32'(zero_flag), 32'd0);
    $display("reset mid-shift: busy=%0b done=%0b result=%02h", busy, done, result);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    do_op(2'd0, 8'hCA, 3'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
